// File: rtl/count_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package count_bcd_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int NSHIFT = 8;
    localparam int NDIG   = 3;
    localparam int DIGW   = 4;
    localparam int BINW   = 8;
    localparam int WORKW  = NDIG * DIGW + BINW;
    localparam int CNTW   = $clog2(NSHIFT);
endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_adj3
    import count_bcd_pkg::*;
(
    input  logic [DIGW-1:0] digit,
    output logic [DIGW-1:0] adjusted
);
    // 4-bit add without carry out; inputs never exceed 9 so no overflow.
    always_comb begin
        adjusted = (digit >= DIGW'(5)) ? digit + DIGW'(3) : digit;
    end
endmodule

// File: rtl/count_bcd_conv.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3) with
// start/busy/done handshake and optional auto-reconvert on input change.
module count_bcd_conv
    import count_bcd_pkg::*;
#(
    parameter bit AUTO = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BINW-1:0] bin,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [DIGW-1:0] hund,
    output logic [DIGW-1:0] tens,
    output logic [DIGW-1:0] ones
);
    state_t                 state_reg, state_next;
    logic [WORKW-1:0]       work_reg, work_next;
    logic [CNTW-1:0]        cnt_reg, cnt_next;
    logic [BINW-1:0]        last_bin_reg, last_bin_next;
    logic [NDIG*DIGW-1:0]   digits_reg, digits_next;
    logic                   done_reg, done_next;
    logic                   busy_reg;
    logic [NDIG*DIGW-1:0]   adj_digits;
    logic [WORKW-1:0]       adj_work;
    logic                   request;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_adj
            bcd_adj3 u_adj (
                .digit    (work_reg[BINW + gi*DIGW +: DIGW]),
                .adjusted (adj_digits[gi*DIGW +: DIGW])
            );
        end
    endgenerate

    assign adj_work = {adj_digits, work_reg[BINW-1:0]};
    assign request  = start || (AUTO && (bin != last_bin_reg));

    always_comb begin
        state_next    = state_reg;
        work_next     = work_reg;
        cnt_next      = cnt_reg;
        last_bin_next = last_bin_reg;
        digits_next   = digits_reg;
        done_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (request) begin
                    state_next    = SHIFT;
                    work_next     = {{(NDIG*DIGW){1'b0}}, bin};
                    last_bin_next = bin;
                    cnt_next      = '0;
                end
            end
            SHIFT: begin
                work_next = {adj_work[WORKW-2:0], 1'b0};
                cnt_next  = cnt_reg + CNTW'(1);
                if (cnt_reg == CNTW'(NSHIFT - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next  = IDLE;
                digits_next = work_reg[WORKW-1:BINW];
                done_next   = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // busy is registered from the next state so it falls on the same edge as the digit update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            work_reg     <= '0;
            cnt_reg      <= '0;
            last_bin_reg <= '0;
            digits_reg   <= '0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            work_reg     <= work_next;
            cnt_reg      <= cnt_next;
            last_bin_reg <= last_bin_next;
            digits_reg   <= digits_next;
            done_reg     <= done_next;
            busy_reg     <= (state_next != IDLE);
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hund = digits_reg[3*DIGW-1:2*DIGW];
    assign tens = digits_reg[2*DIGW-1:DIGW];
    assign ones = digits_reg[DIGW-1:0];
endmodule

// File: tb/tb_count_bcd_conv.sv
// Self-checking bench for count_bcd_conv: directed vectors, corner sequences,
// randomized and AUTO-mode runs against a cycle-level reference model.
module tb_count_bcd_conv;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bin = 8'd0;
    logic       start = 1'b0;
    logic       busy, done;
    logic [3:0] hund, tens, ones;

    logic [7:0] bin_a = 8'd0;
    logic       start_a = 1'b0;
    logic       busy_a, done_a;
    logic [3:0] hund_a, tens_a, ones_a;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    count_bcd_conv #(.AUTO(1'b0)) dut (
        .clk(clk), .rst(rst), .bin(bin), .start(start),
        .busy(busy), .done(done), .hund(hund), .tens(tens), .ones(ones)
    );

    count_bcd_conv #(.AUTO(1'b1)) dut_auto (
        .clk(clk), .rst(rst), .bin(bin_a), .start(start_a),
        .busy(busy_a), .done(done_a), .hund(hund_a), .tens(tens_a), .ones(ones_a)
    );

    typedef struct packed {
        logic [7:0]  b;
        logic [11:0] d;
    } vec_t;
    vec_t vecs [5];

    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a request is taken whenever the converter is free; the
    // result appears 9 edges later and the converter is free again one edge after.
    int          m_wait;
    logic [7:0]  m_last;
    logic [11:0] m_q[$];
    logic [11:0] m_dig;
    logic        m_done_exp;

    task automatic model_reset();
        m_wait = 0; m_last = 8'd0; m_dig = 12'd0; m_done_exp = 1'b0;
        m_q.delete();
    endtask

    task automatic model_edge(input logic s, input logic [7:0] b, input bit auto_mode);
        m_done_exp = (m_wait == 1);
        if (m_done_exp && m_q.size() > 0) m_dig = m_q.pop_front();
        if (m_wait == 0 && (s || (auto_mode && b != m_last))) begin
            m_q.push_back(ref_bcd(b));
            m_last = b;
            m_wait = 10;
        end
        if (m_wait > 0) m_wait--;
    endtask

    task automatic do_conv(input logic [7:0] v, output int lat, output int busy_cnt,
                           output logic [11:0] dig);
        bin = v; start = 1'b1;
        step();
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        for (lat = 1; lat <= 20; lat++) begin
            step();
            if (done) break;
            if (busy) busy_cnt++;
        end
        dig = {hund, tens, ones};
    endtask

    initial begin
        int lat, bcnt, cnt;
        logic [11:0] dig;

        vecs[0] = '{b: 8'd255, d: 12'h255};
        vecs[1] = '{b: 8'd0,   d: 12'h000};
        vecs[2] = '{b: 8'd9,   d: 12'h009};
        vecs[3] = '{b: 8'd10,  d: 12'h010};
        vecs[4] = '{b: 8'd100, d: 12'h100};

        // Reset with random input
        rst = 1'b1; bin = 8'($urandom); start = 1'b0;
        repeat (3) step();
        chk("reset_digits", int'({hund, tens, ones}), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        bin = 8'd0;
        rst = 1'b0;
        cnt = 0;
        repeat (15) begin
            step();
            if (busy || done || busy_a || done_a) cnt++;
        end
        chk("idle_after_reset", cnt, 0);

        // Directed vectors
        for (int i = 0; i < 5; i++) begin
            do_conv(vecs[i].b, lat, bcnt, dig);
            $display("vec bin=%0d digits=%0h lat=%0d", vecs[i].b, dig, lat);
            chk("vec_digits", int'(dig), int'(vecs[i].d));
            chk("vec_latency", lat, 9);
            chk("vec_busy_cycles", bcnt, 9);
            chk("vec_busy_low_at_done", int'(busy), 0);
            step();
            chk("done_one_cycle", int'(done), 0);
            repeat (3) step();
            chk("digits_hold", int'({hund, tens, ones}), int'(vecs[i].d));
        end

        // Start and bin changes while busy are ignored
        bin = 8'd37; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        bin = 8'd200; start = 1'b1;
        step();
        start = 1'b0;
        cnt = 0; dig = 12'd0;
        repeat (25) begin
            step();
            if (done) begin cnt++; dig = {hund, tens, ones}; end
        end
        $display("busy-ignore digits=%0h dones=%0d", dig, cnt);
        chk("ignore_digits", int'(dig), int'(12'h037));
        chk("ignore_done_count", cnt, 1);

        // Reset in the middle of a conversion
        bin = 8'd128; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        #1;
        chk("midrst_digits", int'({hund, tens, ones}), 0);
        chk("midrst_busy", int'(busy), 0);
        step();
        rst = 1'b0;
        cnt = 0;
        repeat (15) begin
            step();
            if (done || busy) cnt++;
        end
        chk("midrst_no_done", cnt, 0);
        do_conv(8'd128, lat, bcnt, dig);
        $display("after reset bin=128 digits=%0h lat=%0d", dig, lat);
        chk("midrst_reconv", int'(dig), int'(12'h128));
        chk("midrst_latency", lat, 9);

        // Exhaustive sweep
        for (int v = 0; v < 256; v++) begin
            do_conv(8'(v), lat, bcnt, dig);
            $display("sweep bin=%0d digits=%0h", v, dig);
            chk("sweep_digits", int'(dig), int'(ref_bcd(v)));
        end

        // Back-to-back with start held, then random start/bin, against the model
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 200; c++) begin
            start = (c < 40) ? 1'b1 : 1'(($urandom % 3) == 0);
            bin = 8'($urandom);
            model_edge(start, bin, 1'b0);
            step();
            chk("rand_busy", int'(busy), int'(m_wait != 0));
            chk("rand_done", int'(done), int'(m_done_exp));
            chk("rand_digits", int'({hund, tens, ones}), int'(m_dig));
            if (done) $display("rand done digits=%0h", {hund, tens, ones});
        end
        start = 1'b0;

        // AUTO mode tracking a live up-counter
        model_reset();
        for (int c = 0; c < 160; c++) begin
            if (c > 0 && c < 130) bin_a = bin_a + 8'd1;
            model_edge(1'b0, bin_a, 1'b1);
            step();
            chk("auto_busy", int'(busy_a), int'(m_wait != 0));
            chk("auto_done", int'(done_a), int'(m_done_exp));
            chk("auto_digits", int'({hund_a, tens_a, ones_a}), int'(m_dig));
            if (done_a) $display("auto done digits=%0h", {hund_a, tens_a, ones_a});
        end
        chk("auto_final", int'({hund_a, tens_a, ones_a}), int'(ref_bcd(int'(bin_a))));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
